// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types, funct3 memctrl codes and alignment helper for mem_arbiter
package mem_arb_pkg;

    localparam logic [2:0] MC_B  = 3'b000;
    localparam logic [2:0] MC_H  = 3'b001;
    localparam logic [2:0] MC_W  = 3'b010;
    localparam logic [2:0] MC_BU = 3'b100;
    localparam logic [2:0] MC_HU = 3'b101;

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    typedef logic port_t;

    // Halfwords need bit 0 clear, words need both low bits clear; bytes are always aligned.
    function automatic logic is_misaligned(input logic [2:0] ctrl, input logic [1:0] addr_lo);
        case (ctrl)
            MC_H, MC_HU: return addr_lo[0];
            MC_W:        return |addr_lo;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-input round-robin arbiter; on a tie the port that did not win last time is granted
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic [1:0] valid_i,
    input  logic       en_i,
    input  port_t      last_i,
    output port_t      grant_o,
    output logic       any_o
);

    assign any_o   = en_i & (|valid_i);
    assign grant_o = (&valid_i) ? ~last_i : valid_i[1];

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter in front of a single-port fixed-latency data memory
// Optional misalignment check enabled by defining MEM_ARB_ALIGN_CHK_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0]             req_we,
    input  logic [1:0][2:0]        req_ctrl,
    input  logic [1:0][ADDR_W-1:0] req_addr,
    input  logic [1:0][DATA_W-1:0] req_wdata,
    output logic [1:0]             rsp_valid,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   rsp_err,
    output logic                   mem_re,
    output logic                   mem_we,
    output logic [2:0]             mem_ctrl,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic [DATA_W-1:0]      mem_rdata
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);

    state_e           state_q;
    port_t            gnt_q;
    port_t            last_q;
    logic             we_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    port_t gnt;
    logic  accept;
    logic  acc_err;
    logic  rsp_fire;

    // Grants are suppressed while reset is asserted so nothing is accepted in that cycle.
    rr_arbiter2 u_rr (
        .valid_i (req_valid),
        .en_i    ((state_q == IDLE) & ~rst),
        .last_i  (last_q),
        .grant_o (gnt),
        .any_o   (accept)
    );

`ifdef MEM_ARB_ALIGN_CHK_EN
    assign acc_err = accept & is_misaligned(req_ctrl[gnt], req_addr[gnt][1:0]);
`else
    assign acc_err = 1'b0;
`endif

    assign cnt_d    = cnt_q - CNT_W'(1);
    assign rsp_fire = (state_q == BUSY) && (cnt_q == CNT_W'(1));

    always_comb begin
        req_ready = '0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_ctrl  = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (accept) begin
            req_ready[gnt] = 1'b1;
            mem_re         = ~req_we[gnt] & ~acc_err;
            mem_we         = req_we[gnt] & ~acc_err;
            mem_ctrl       = req_ctrl[gnt];
            mem_addr       = req_addr[gnt];
            mem_wdata      = req_wdata[gnt];
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (rsp_fire) begin
            rsp_valid[gnt_q] = 1'b1;
        end
    end

    // Stores and rejected accesses return zero data; memory data is only meaningful for a real load.
    assign rsp_rdata = (rsp_fire && !we_q && !err_q) ? mem_rdata : '0;

`ifdef MEM_ARB_ALIGN_CHK_EN
    assign rsp_err = rsp_fire & err_q;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= BUSY;
                        gnt_q   <= gnt;
                        last_q  <= gnt;
                        we_q    <= req_we[gnt];
                        err_q   <= acc_err;
                        cnt_q   <= CNT_W'(MEM_LAT);
                    end
                end
                BUSY: begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized scoreboard bench for mem_arbiter with a latency-pipelined memory model
module tb_mem_arbiter;

    localparam int LAT = 3;

    typedef struct packed {
        logic        we;
        logic [2:0]  ctrl;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        int          due;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic v0, v1;
    req_t f0, f1;

    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0]        req_we;
    logic [1:0][2:0]   req_ctrl;
    logic [1:0][31:0]  req_addr;
    logic [1:0][31:0]  req_wdata;
    logic [1:0]        rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              mem_re, mem_we;
    logic [2:0]        mem_ctrl;
    logic [31:0]       mem_addr, mem_wdata, mem_rdata;

    assign req_valid = {v1, v0};
    assign req_we    = {f1.we, f0.we};
    assign req_ctrl  = {f1.ctrl, f0.ctrl};
    assign req_addr  = {f1.addr, f0.addr};
    assign req_wdata = {f1.wdata, f0.wdata};

    mem_arbiter #(.MEM_LAT(LAT), .ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_ctrl  (req_ctrl),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_ctrl  (mem_ctrl),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    bit   gaps  = 1'b0;
    req_t pq0[$];
    req_t pq1[$];
    exp_t eq0[$];
    exp_t eq1[$];
    int   glog_port[$];
    int   glog_cyc[$];

    function automatic logic [31:0] init_word(input int i);
        return (i == 4) ? 32'hDEADBEEF : (32'hA5000000 | (32'(i) * 32'h00010203));
    endfunction

    function automatic req_t mk(input logic we, input logic [2:0] ctrl, input logic [31:0] addr,
                                input logic [31:0] wdata);
        req_t r;
        r.we = we; r.ctrl = ctrl; r.addr = addr; r.wdata = wdata;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Memory with a LAT-deep read pipe; unread cycles return a marker pattern, not zero.
    logic [31:0] mem [64];
    logic [31:0] pipe [LAT];
    bit          mem_init = 1'b0;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
            mem_init <= 1'b1;
        end else if (mem_we) begin
            mem[mem_addr[7:2]] <= mem_wdata;
        end
        pipe[0] <= mem_re ? mem[mem_addr[7:2]] : 32'h5A5A5A5A;
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign mem_rdata = pipe[LAT-1];

    // Driver: holds each request until it is seen accepted, then presents the next one.
    initial begin
        logic [1:0] rdy;
        v0 = 1'b0; v1 = 1'b0; f0 = '0; f1 = '0;
        forever begin
            @(negedge clk);
            rdy = req_ready;
            @(posedge clk);
            #1;
            if (!v0 || rdy[0]) begin
                if (pq0.size() > 0 && (!gaps || $urandom_range(0, 1) == 1)) begin
                    f0 = pq0.pop_front(); v0 = 1'b1;
                end else v0 = 1'b0;
            end
            if (!v1 || rdy[1]) begin
                if (pq1.size() > 0 && (!gaps || $urandom_range(0, 1) == 1)) begin
                    f1 = pq1.pop_front(); v1 = 1'b1;
                end else v1 = 1'b0;
            end
        end
    end

    // Reference model and monitor: whenever the arbiter is free and anyone asks, a grant must occur.
    initial begin
        logic [31:0] ref_mem [64];
        int          cyc = 0;
        int          last = 1;
        int          nfree = 0;
        int          g;
        logic [1:0]  pv = '0;
        logic [1:0]  pr = '0;
        req_t        pf0, pf1, r;
        exp_t        e;
        logic        err, have;
        pf0 = '0; pf1 = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                chk("ready_in_reset", 32'(req_ready), 32'h0);
                eq0.delete(); eq1.delete();
                last = 1; nfree = cyc + 1; pv = '0;
                continue;
            end
            chk("rsp_onehot", 32'(rsp_valid == 2'b11), 32'h0);
            chk("re_we_excl", 32'(mem_re & mem_we), 32'h0);
            if (pv[0] && !pr[0]) chk("valid_held_p0", 32'(v0 && f0 == pf0), 32'h1);
            if (pv[1] && !pr[1]) chk("valid_held_p1", 32'(v1 && f1 == pf1), 32'h1);

            for (int p = 0; p < 2; p++) begin
                have = 1'b0;
                if (p == 0 && eq0.size() > 0 && eq0[0].due == cyc) begin e = eq0.pop_front(); have = 1'b1; end
                if (p == 1 && eq1.size() > 0 && eq1[0].due == cyc) begin e = eq1.pop_front(); have = 1'b1; end
                if (have) begin
                    chk($sformatf("rsp_valid_p%0d", p), 32'(rsp_valid[p]), 32'h1);
                    chk($sformatf("rsp_rdata_p%0d", p), rsp_rdata, e.rdata);
                    chk($sformatf("rsp_err_p%0d", p), 32'(rsp_err), 32'(e.err));
                end else if (rsp_valid[p]) begin
                    chk($sformatf("rsp_unexpected_p%0d", p), 32'(rsp_valid[p]), 32'h0);
                end
            end
            if (rsp_valid == 2'b00) begin
                chk("rsp_rdata_idle", rsp_rdata, 32'h0);
                chk("rsp_err_idle", 32'(rsp_err), 32'h0);
            end

            if (cyc >= nfree && req_valid != 2'b00) begin
                if (req_valid == 2'b11) g = (last == 0) ? 1 : 0;
                else g = req_valid[1] ? 1 : 0;
                chk("req_ready", 32'(req_ready), 32'(2'b01 << g));
                r = (g == 1) ? f1 : f0;
`ifdef MEM_ARB_ALIGN_CHK_EN
                err = ((r.ctrl == 3'b001 || r.ctrl == 3'b101) && r.addr[0]) ||
                      (r.ctrl == 3'b010 && r.addr[1:0] != 2'b00);
`else
                err = 1'b0;
`endif
                chk("mem_re", 32'(mem_re), 32'(!r.we && !err));
                chk("mem_we", 32'(mem_we), 32'(r.we && !err));
                chk("mem_ctrl", 32'(mem_ctrl), 32'(r.ctrl));
                chk("mem_addr", mem_addr, r.addr);
                chk("mem_wdata", mem_wdata, r.wdata);
                e.due = cyc + LAT;
                e.err = err;
                e.rdata = (r.we || err) ? 32'h0 : ref_mem[r.addr[7:2]];
                if (r.we && !err) ref_mem[r.addr[7:2]] = r.wdata;
                if (g == 1) eq1.push_back(e); else eq0.push_back(e);
                glog_port.push_back(g);
                glog_cyc.push_back(cyc);
                last = g;
                nfree = cyc + LAT + 1;
            end else begin
                chk("req_ready_idle", 32'(req_ready), 32'h0);
                chk("mem_strobe_idle", 32'({mem_re, mem_we}), 32'h0);
                chk("mem_bus_idle", mem_addr | mem_wdata | 32'(mem_ctrl), 32'h0);
            end
            pv = req_valid; pr = req_ready; pf0 = f0; pf1 = f1;
        end
    end

    task automatic wait_idle(input int maxc);
        int n = 0;
        while ((pq0.size() > 0 || pq1.size() > 0 || v0 || v1 || eq0.size() > 0 || eq1.size() > 0)
               && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("drain_within_budget", 32'(n < maxc), 32'h1);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 32'h0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'h0);
        chk({tag, "_mem_strobes"}, 32'({mem_re, mem_we}), 32'h0);
        chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    endtask

    initial begin
        logic [2:0] cl [5];
        int n;
        cl[0] = 3'b000; cl[1] = 3'b001; cl[2] = 3'b010; cl[3] = 3'b100; cl[4] = 3'b101;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_quiet("reset");

        pq0.push_back(mk(1'b0, 3'b010, 32'h10, 32'h0));
        wait_idle(50);

        pq0.push_back(mk(1'b1, 3'b010, 32'h20, 32'h12345678));
        pq0.push_back(mk(1'b0, 3'b010, 32'h20, 32'h0));
        wait_idle(50);

        // Reset while a load is in flight: its response must never appear.
        pq0.push_back(mk(1'b0, 3'b010, 32'h30, 32'h0));
        n = 0;
        while (eq0.size() == 0 && n < 50) begin @(negedge clk); n++; end
        chk("inflight_accepted", 32'(eq0.size()), 32'h1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_quiet("midbusy_reset");
        repeat (LAT + 2) @(negedge clk);

        glog_port.delete(); glog_cyc.delete();
        for (int i = 0; i < 3; i++) begin
            pq0.push_back(mk(1'($urandom_range(0, 1)), 3'b010, {24'h0, 6'($urandom_range(0, 63)), 2'b00}, $urandom));
            pq1.push_back(mk(1'($urandom_range(0, 1)), 3'b010, {24'h0, 6'($urandom_range(0, 63)), 2'b00}, $urandom));
        end
        wait_idle(100);
        chk("contention_count", 32'(glog_port.size()), 32'd6);
        for (int i = 0; i < 6 && i < glog_port.size(); i++) begin
            chk($sformatf("contention_grant_%0d", i), 32'(glog_port[i]), 32'(i % 2));
            if (i > 0) chk($sformatf("contention_gap_%0d", i), 32'(glog_cyc[i] - glog_cyc[i-1]), 32'(LAT + 1));
        end

        pq1.push_back(mk(1'b0, 3'b100, 32'h23, 32'h0));
        pq0.push_back(mk(1'b1, 3'b001, 32'h22, 32'h0000BEEF));
        wait_idle(50);

`ifdef MEM_ARB_ALIGN_CHK_EN
        pq0.push_back(mk(1'b0, 3'b010, 32'h22, 32'h0));
        pq0.push_back(mk(1'b0, 3'b001, 32'h22, 32'h0));
        wait_idle(50);
`endif

        gaps = 1'b1;
        for (int i = 0; i < 40; i++) begin
            pq0.push_back(mk(1'($urandom_range(0, 1)), cl[$urandom_range(0, 4)], 32'($urandom_range(0, 255)), $urandom));
            pq1.push_back(mk(1'($urandom_range(0, 1)), cl[$urandom_range(0, 4)], 32'($urandom_range(0, 255)), $urandom));
        end
        wait_idle(3000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
